regfile_2r1w_sb: RTL and testbench
==================================

# regfile_2r1w_sb

General-purpose register file for the npc core: two combinational read ports, one synchronous write port, and a per-register pending (scoreboard) bit. It replaces the single-read-port array with fixed per-register taps. It sits between decode (reads, issue marking) and write-back (writes, pending clear). Width, depth and the hardwired-zero register are parameters. Write-to-read forwarding is a compile-time option.

## Interface
- `ADDR_WIDTH`, 5, register index width; depth NREGS = 2**ADDR_WIDTH
- `DATA_WIDTH`, 32, register width
- `ZERO_REG`, 1, 1 = register 0 hardwired to zero and never pending; 0 = register 0 is ordinary storage

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `wen`  in  1  write enable (write-back)
- `waddr`  in  ADDR_WIDTH  write index
- `wdata`  in  DATA_WIDTH  write data
- `raddr1`, `raddr2`  in  ADDR_WIDTH  read indices
- `rdata1`, `rdata2`  out  DATA_WIDTH  read data, combinational
- `busy1`, `busy2`  out  1  the register addressed by raddrN has an outstanding producer
- `issue_en`  in  1  mark a destination pending (decode issue)
- `issue_rd`  in  ADDR_WIDTH  destination index to mark
- `dbg_addr`  in  ADDR_WIDTH  debug/difftest read index
- `dbg_data`  out  DATA_WIDTH  debug read data; same rules as a read port, never bypassed
- `pending_any`  out  1  OR of all pending bits (drain/fence indication)

## Operation
- Storage: NREGS × DATA_WIDTH array `rf` and an NREGS-bit vector `pending`.
- Reset (rst_n low, asynchronous): every `rf` entry is 0 and every pending bit is 0. Outputs while in reset: rdata1/2 = 0, dbg_data = 0, busy1/2 = 0, pending_any = 0. Deassertion takes effect at the next clk edge; that edge performs no write and no issue unless wen/issue_en are high.
- Write: at the clk edge with wen=1, `rf[waddr]` is set to wdata and `pending[waddr]` is cleared. With ZERO_REG=1 and waddr=0, the write is dropped.
- Issue: at the clk edge with issue_en=1, `pending[issue_rd]` is set. With ZERO_REG=1 and issue_rd=0, the issue is ignored. Issuing an already-pending register leaves the bit at 1. There is no counting: one outstanding producer per register.
- Same edge, wen and issue_en to the same index: data is written, and pending ends at 1. Issue wins because the new producer is younger.
- Read: rdataN = 0 if ZERO_REG=1 and raddrN=0; otherwise `rf[raddrN]`. busyN = `pending[raddrN]`, which is always 0 for index 0 when ZERO_REG=1.
- Both read ports, dbg, write and issue may address the same index in one cycle. There are no conflicts or stalls.
- pending_any is combinational from the pending vector.

## Timing
- Read latency: 0 cycles, combinational from raddrN and state.
- Write visibility, without bypass: new value visible on rdataN/dbg_data in the cycle after the write edge. busyN falls in the same cycle.
- Issue visibility: busyN rises in the cycle after the issue edge.
- No handshake: wen and issue_en are single-cycle strobes, accepted unconditionally every cycle.
- Reset asserted mid-write cycle: the write is lost. State is 0 immediately, not at the edge.

## Configuration
- `RF_BYPASS_EN` defined: when wen=1, waddr=raddrN, and the index is not hardwired zero, rdataN = wdata and busyN = 0 in the same cycle. busyN stays 1 if issue_en=1 with issue_rd=raddrN in that cycle. dbg_data is never bypassed.
- `RF_BYPASS_EN` undefined: no forwarding. Read ports see the array only, and timing is as above.

## Test plan
- Reset then read: pulse rst_n low mid-cycle. -> rdata1 = rdata2 = dbg_data = 0, busy1 = busy2 = 0, pending_any = 0 immediately.
- Write/read: write r5 = 0xDEADBEEF; next cycle set raddr1 = 5, raddr2 = 0. -> rdata1 = 0xDEADBEEF, rdata2 = 0. Write r0 = 0x1234 (ZERO_REG=1). -> r0 reads 0 and busy stays 0.
- Scoreboard: issue r7; next cycle raddr1 = 7. -> busy1 = 1, pending_any = 1. Write r7 = 0x55. -> next cycle busy1 = 0, rdata1 = 0x55, pending_any = 0.
- Collision: r3 pending; same edge wen to r3 = 0xA5A5A5A5 and issue_en to r3. -> next cycle rdata = 0xA5A5A5A5, busy = 1.
- Bypass (RF_BYPASS_EN): r9 = 0x11 and pending; cycle with wen to r9 = 0x22 and raddr1 = raddr2 = 9. -> same cycle rdata1 = rdata2 = 0x22, busy1 = busy2 = 0, dbg_data (dbg_addr = 9) = 0x11. Without the macro: rdata1 = 0x11 and busy1 = 1 that cycle.
- Parameters: ADDR_WIDTH = 4, DATA_WIDTH = 64, ZERO_REG = 0. Write r0 = 0xFFFF_FFFF_FFFF_FFFF and r15 = 1. -> both read back exactly; issue r0 -> busy = 1.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// General-purpose register file for npc: two combinational read ports, one write port, a debug tap
// and a per-register pending (scoreboard) bit. Optional same-cycle write forwarding under RF_BYPASS_EN.
module regfile_2r1w_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  busy1,
    output logic                  busy2,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  pending_any
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf [NREGS];
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_next;

    // Index 0 is a sink/constant when ZERO_REG is set.
    logic wr_act, iss_act, r1_zero, r2_zero, dbg_zero;

    always_comb begin
        wr_act   = wen      && !(ZERO_REG && (waddr    == '0));
        iss_act  = issue_en && !(ZERO_REG && (issue_rd == '0));
        r1_zero  = ZERO_REG && (raddr1   == '0);
        r2_zero  = ZERO_REG && (raddr2   == '0);
        dbg_zero = ZERO_REG && (dbg_addr == '0);
    end

    // Clear from write-back is applied before set from issue, so a same-edge issue wins.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns a default first so no latch is inferred.
        pending_next = pending;
        if (wr_act) begin
            pending_next[waddr] = 1'b0;
        end
        if (iss_act) begin
            pending_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because every register must read 0 after reset; this
            // costs flops instead of a RAM macro, which is acceptable at this depth.
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
            pending <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all updates land together at the edge.
            if (wr_act) begin
                rf[waddr] <= wdata;
            end
            pending <= pending_next;
        end
    end

    always_comb begin
        rdata1   = r1_zero  ? '0 : rf[raddr1];
        rdata2   = r2_zero  ? '0 : rf[raddr2];
        busy1    = r1_zero  ? 1'b0 : pending[raddr1];
        busy2    = r2_zero  ? 1'b0 : pending[raddr2];
        dbg_data = dbg_zero ? '0 : rf[dbg_addr];
`ifdef RF_BYPASS_EN
        // Forward the in-flight write; gated by rst_n so outputs stay 0 while in reset.
        if (rst_n && wr_act && (waddr == raddr1)) begin
            rdata1 = wdata;
            busy1  = iss_act && (issue_rd == raddr1);
        end
        if (rst_n && wr_act && (waddr == raddr2)) begin
            rdata2 = wdata;
            busy2  = iss_act && (issue_rd == raddr2);
        end
`endif
    end

    assign pending_any = |pending;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Scoreboard bench for regfile_2r1w_sb: the default instance plus a 16x64, ZERO_REG=0 instance.
// Stimulus pushes expected read-side values; a negedge monitor pops and compares them.
module tb_regfile_2r1w_sb;

    typedef struct {
        int          which;   // 0 = default instance, 1 = parameterised instance
        string       name;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] dbg;
        logic        b1;
        logic        b2;
        logic        pany;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        wen = 0, issue_en = 0;
    logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0, issue_rd = '0, dbg_addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata1, rdata2, dbg_data;
    logic        busy1, busy2, pending_any;

    logic        p_wen = 0, p_issue_en = 0;
    logic [3:0]  p_waddr = '0, p_raddr1 = '0, p_raddr2 = '0, p_issue_rd = '0, p_dbg_addr = '0;
    logic [63:0] p_wdata = '0;
    logic [63:0] p_rdata1, p_rdata2, p_dbg_data;
    logic        p_busy1, p_busy2, p_pending_any;

    regfile_2r1w_sb dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2), .issue_en(issue_en), .issue_rd(issue_rd),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pending_any(pending_any)
    );

    regfile_2r1w_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .ZERO_REG(1'b0)) dut_p (
        .clk(clk), .rst_n(rst_n), .wen(p_wen), .waddr(p_waddr), .wdata(p_wdata),
        .raddr1(p_raddr1), .raddr2(p_raddr2), .rdata1(p_rdata1), .rdata2(p_rdata2),
        .busy1(p_busy1), .busy2(p_busy2), .issue_en(p_issue_en), .issue_rd(p_issue_rd),
        .dbg_addr(p_dbg_addr), .dbg_data(p_dbg_data), .pending_any(p_pending_any)
    );

    task automatic check(input exp_t e);
        logic [63:0] a1, a2, ad;
        logic        ab1, ab2, ap;
        if (e.which == 0) begin
            a1 = {32'h0, rdata1}; a2 = {32'h0, rdata2}; ad = {32'h0, dbg_data};
            ab1 = busy1; ab2 = busy2; ap = pending_any;
        end else begin
            a1 = p_rdata1; a2 = p_rdata2; ad = p_dbg_data;
            ab1 = p_busy1; ab2 = p_busy2; ap = p_pending_any;
        end
        tests_run++;
        if (a1 !== e.r1 || a2 !== e.r2 || ad !== e.dbg || ab1 !== e.b1 || ab2 !== e.b2 || ap !== e.pany) begin
            tests_failed++;
            $display("FAIL %s: got r1=%h r2=%h dbg=%h b1=%b b2=%b pany=%b, want r1=%h r2=%h dbg=%h b1=%b b2=%b pany=%b",
                     e.name, a1, a2, ad, ab1, ab2, ap, e.r1, e.r2, e.dbg, e.b1, e.b2, e.pany);
        end
    endtask

    // Monitor: the register file presents its outputs every cycle; sample mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            check(exp_q.pop_front());
        end
    end

    task automatic expect_rf(input int which, input string name, input logic [63:0] r1, input logic [63:0] r2,
                             input logic [63:0] dbg, input logic b1, input logic b2, input logic pany);
        exp_t e;
        e.which = which; e.name = name; e.r1 = r1; e.r2 = r2; e.dbg = dbg;
        e.b1 = b1; e.b2 = b2; e.pany = pany;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        raddr1 = 5'd5; raddr2 = 5'd9; dbg_addr = 5'd5;
        expect_rf(0, "reset_state", 64'h0, 64'h0, 64'h0, 0, 0, 0);
        step(); step();
        rst_n = 1'b1;

        // Write r5, then read it on port 1 and r0 on port 2.
        wen = 1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        wen = 0; raddr1 = 5'd5; raddr2 = 5'd0; dbg_addr = 5'd5;
        expect_rf(0, "write_read_r5", 64'hDEADBEEF, 64'h0, 64'hDEADBEEF, 0, 0, 0);

        // r0 is hardwired: write and issue to it are both dropped.
        step();
        wen = 1; waddr = 5'd0; wdata = 32'h1234; issue_en = 1; issue_rd = 5'd0;
        raddr1 = 5'd1; raddr2 = 5'd1; dbg_addr = 5'd1;
        step();
        wen = 0; issue_en = 0; raddr1 = 5'd0; raddr2 = 5'd0; dbg_addr = 5'd0;
        expect_rf(0, "zero_reg", 64'h0, 64'h0, 64'h0, 0, 0, 0);

        // Scoreboard set by issue, cleared by write-back.
        step();
        issue_en = 1; issue_rd = 5'd7;
        step();
        issue_en = 0; raddr1 = 5'd7;
        expect_rf(0, "issue_r7_busy", 64'h0, 64'h0, 64'h0, 1, 0, 1);
        step();
        wen = 1; waddr = 5'd7; wdata = 32'h55; raddr1 = 5'd2;
        step();
        wen = 0; raddr1 = 5'd7;
        expect_rf(0, "writeback_r7", 64'h55, 64'h0, 64'h0, 0, 0, 0);

        // Collision: r3 pending, then write and issue r3 on the same edge.
        step();
        issue_en = 1; issue_rd = 5'd3;
        step();
        wen = 1; waddr = 5'd3; wdata = 32'hA5A5A5A5; issue_rd = 5'd3;
        raddr1 = 5'd3; raddr2 = 5'd0; dbg_addr = 5'd3;
`ifdef RF_BYPASS_EN
        expect_rf(0, "collision_cycle", 64'hA5A5A5A5, 64'h0, 64'h0, 1, 0, 1);
`else
        expect_rf(0, "collision_cycle", 64'h0, 64'h0, 64'h0, 1, 0, 1);
`endif
        step();
        wen = 0; issue_en = 0; raddr1 = 5'd3; raddr2 = 5'd3;
        expect_rf(0, "collision_after", 64'hA5A5A5A5, 64'hA5A5A5A5, 64'hA5A5A5A5, 1, 1, 1);
        step();
        wen = 1; waddr = 5'd3; wdata = 32'hA5A5A5A5; raddr1 = 5'd0; raddr2 = 5'd0; dbg_addr = 5'd0;

        // Forwarding: r9 = 0x11 and pending, then write 0x22 while reading r9.
        step();
        wen = 1; waddr = 5'd9; wdata = 32'h11;
        step();
        wen = 0; issue_en = 1; issue_rd = 5'd9;
        step();
        issue_en = 0; wen = 1; waddr = 5'd9; wdata = 32'h22;
        raddr1 = 5'd9; raddr2 = 5'd9; dbg_addr = 5'd9;
`ifdef RF_BYPASS_EN
        expect_rf(0, "bypass_cycle", 64'h22, 64'h22, 64'h11, 0, 0, 1);
`else
        expect_rf(0, "bypass_cycle", 64'h11, 64'h11, 64'h11, 1, 1, 1);
`endif
        step();
        wen = 0;
        expect_rf(0, "bypass_after", 64'h22, 64'h22, 64'h22, 0, 0, 0);

        // Parameterised instance: ordinary r0, full-width data, top index.
        step();
        p_wen = 1; p_waddr = 4'd0; p_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        p_waddr = 4'd15; p_wdata = 64'h1; p_raddr1 = 4'd0; p_raddr2 = 4'd1; p_dbg_addr = 4'd0;
        expect_rf(1, "p_r0_write", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        step();
        p_wen = 0; p_raddr2 = 4'd15; p_dbg_addr = 4'd15;
        expect_rf(1, "p_r0_r15", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 0, 0, 0);
        step();
        p_issue_en = 1; p_issue_rd = 4'd0;
        step();
        p_issue_en = 0;
        expect_rf(1, "p_issue_r0", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 1, 0, 1);

        // Reset pulled mid-cycle while a write and an issue are in flight.
        step();
        wen = 1; waddr = 5'd9; wdata = 32'h33; issue_en = 1; issue_rd = 5'd4;
        raddr1 = 5'd9; raddr2 = 5'd4; dbg_addr = 5'd9;
        #2;
        rst_n = 1'b0;
        expect_rf(0, "reset_midcycle", 64'h0, 64'h0, 64'h0, 0, 0, 0);
        expect_rf(1, "p_reset_midcycle", 64'h0, 64'h0, 64'h0, 0, 0, 0);
        step();
        rst_n = 1'b1; wen = 0; issue_en = 0;
        expect_rf(0, "after_reset", 64'h0, 64'h0, 64'h0, 0, 0, 0);
        step();
        raddr1 = 5'd5; raddr2 = 5'd7;
        expect_rf(0, "after_reset_r5_r7", 64'h0, 64'h0, 64'h0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            step();
        end
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
